kbd_ctrl: RTL and testbench
===========================

KBD_CTRL -- requirements
Module: kbd_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, scancode FIFO entries; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx_data  input  8  scancode from PS/2 receiver; valid when rx_rdy=1.
REQ-005 SHALL have port rx_rdy  input  1  one-cycle pulse: new scancode on rx_data.
REQ-006 SHALL have port en  input  1  bus access strobe.
REQ-007 SHALL have port wr  input  1  1=write, 0=read; sampled only when en=1.
REQ-008 SHALL have port addr  input  1  0=control/status register, 1=data register.
REQ-009 SHALL have port data_in  input  32  bus write data.
REQ-010 SHALL have port data_out  output  32  bus read data, combinational from registered state.
REQ-011 SHALL have port wt  output  1  bus wait; constant 0.
REQ-012 SHALL have port irq  output  1  interrupt request, level.

Function
REQ-013 SHALL, on rx_rdy=1 with buffer not full, push rx_data in the same cycle; visible to reads next cycle.
REQ-014 SHALL, on rx_rdy=1 with buffer full and no pop that cycle, drop rx_data, keep buffer contents, set overrun=1.
REQ-015 SHALL, on rx_rdy=1 with buffer full and data-register read that cycle, perform pop then push; no overrun.
REQ-016 SHALL, on read of addr 1 with buffer non-empty, return {24'b0, oldest entry} and pop it at the clock edge.
REQ-017 SHALL, on read of addr 1 with buffer empty, return 32'h0; no state change.
REQ-018 SHALL return on read of addr 0: bit0=ready (buffer non-empty), bit1=ien, bit2=overrun, bits7:4=occupancy count, other bits 0.
REQ-019 SHALL, on write to addr 0, set ien:=data_in[1]; overrun cleared when data_in[2]=1 (write-1-to-clear).
REQ-020 SHALL ignore writes to addr 1.
REQ-021 SHALL drive irq = ien & (ready | overrun), registered; follows state change by one cycle.
REQ-022 SHALL manage FIFO pointers modulo FIFO_DEPTH with occupancy counter 0..FIFO_DEPTH; full when count=FIFO_DEPTH, empty when 0.
REQ-023 SHALL, on overrun set and clear in the same cycle, keep overrun=1 (set wins).

Reset
REQ-024 SHALL, while rst=1, clear read/write pointers, count, ien, overrun, irq; data_out then reads 0 on both addresses.
REQ-025 SHALL discard buffered scancodes on reset mid-operation; rx_rdy and bus accesses during rst ignored.

Configuration
REQ-026 SHALL, with KBD_CTRL_FIFO_EN defined, implement the FIFO_DEPTH-entry buffer as above.
REQ-027 SHALL, without KBD_CTRL_FIFO_EN, use a single holding register: effective depth 1, count bits 7:4 read 0 or 1, overrun/pop/push rules unchanged with depth 1.

Structure
REQ-028 SHALL take register addresses, status bit positions and the default depth from shared package kbd_pkg.
REQ-029 SHALL place the storage in sub-module kbd_fifo (push, pop, data out, count, full, empty); kbd_ctrl holds bus decode, ien, overrun, irq.

Verification
REQ-030 SHALL cover: reset, then read addr 0 -> 32'h0; irq=0.
REQ-031 SHALL cover: pulses rx_data=8'h1C then 8'hF0, ien=1 -> status 32'h23; irq=1 next cycle; reads addr 1 give 32'h1C then 32'hF0; status then 32'h02, irq=0.
REQ-032 SHALL cover: 9 pulses (8'h01..8'h09), depth 8, no reads -> status 32'h85; eight reads give 01..08; 8'h09 lost.
REQ-033 SHALL cover: buffer full, rx_rdy(8'hAA) coincident with addr-1 read -> read returns oldest, overrun stays 0, 8'hAA read last.
REQ-034 SHALL cover: overrun=1, ien=0 -> irq=0; write addr 0 with 32'h6 -> ien=1, overrun=0, irq follows ready only.
REQ-035 SHALL cover: rst asserted with 3 entries buffered -> status 32'h0 after reset; subsequent addr-1 read returns 32'h0.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard controller: register map, status bit layout, default depth.
package kbd_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 8;

  localparam logic ADDR_CTRL = 1'b0;
  localparam logic ADDR_DATA = 1'b1;

  localparam int ST_READY    = 0;
  localparam int ST_IEN      = 1;
  localparam int ST_OVR      = 2;
  localparam int ST_CNT_LSB  = 4;
  localparam int ST_CNT_W    = 4;
  localparam int ST_CNT_MAX  = 15;

endpackage

// File: rtl/kbd_fifo.sv
// Scancode storage: power-of-two ring buffer, or a single holding register when DEPTH is 1.
module kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (push && !pop) begin
      count_reg <= count_reg + 1'b1;
    end else if (pop && !push) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  generate
    if (DEPTH == 1) begin : g_hold
      logic [7:0] hold_reg;

      always_ff @(posedge clk) begin
        if (push) hold_reg <= din;
      end

      assign dout = hold_reg;
    end else begin : g_ring
      localparam int PTR_W = $clog2(DEPTH);

      logic [7:0]       mem [DEPTH];
      logic [PTR_W-1:0] wr_ptr_reg;
      logic [PTR_W-1:0] rd_ptr_reg;

      // Depth is a power of two, so natural pointer overflow gives the modulo wrap.
      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= din;
      end

      assign dout = mem[rd_ptr_reg];
    end
  endgenerate

endmodule

// File: rtl/kbd_ctrl.sv
// PS/2 keyboard controller bus front end: status/data registers, overrun and interrupt.
// Define KBD_CTRL_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise a single holding register.
module kbd_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  input  logic        en,
  input  logic        wr,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        wt,
  output logic        irq
);

`ifdef KBD_CTRL_FIFO_EN
  localparam int EFF_DEPTH = FIFO_DEPTH;
`else
  localparam int EFF_DEPTH = 1;
  localparam int unused_fifo_depth = FIFO_DEPTH;
`endif
  localparam int CNT_W = $clog2(EFF_DEPTH + 1);

  logic             ien_reg;
  logic             overrun_reg;
  logic             irq_reg;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic             rd_data;
  logic             wr_ctrl;
  logic             pop;
  logic             push;
  logic             ovr_set;
  logic [ST_CNT_W-1:0] cnt_field;
  logic [31:0]      status;
  logic             unused_data_in;

  assign rd_data = en && !wr && (addr == ADDR_DATA);
  assign wr_ctrl = en && wr && (addr == ADDR_CTRL);

  // A full buffer still accepts a new byte when the same cycle pops the oldest.
  assign pop     = rd_data && !fifo_empty && !rst;
  assign push    = rx_rdy && !rst && (!fifo_full || pop);
  assign ovr_set = rx_rdy && fifo_full && !pop;

  kbd_fifo #(
    .DEPTH (EFF_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rx_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A 16-entry buffer cannot show 16 in a 4-bit field, so the field saturates.
  always_comb begin
    cnt_field = ST_CNT_W'(fifo_count);
    if (int'(fifo_count) > ST_CNT_MAX) cnt_field = ST_CNT_W'(ST_CNT_MAX);
  end

  always_comb begin
    status                            = '0;
    status[ST_READY]                  = !fifo_empty;
    status[ST_IEN]                    = ien_reg;
    status[ST_OVR]                    = overrun_reg;
    status[ST_CNT_LSB +: ST_CNT_W]    = cnt_field;
  end

  always_comb begin
    data_out = '0;
    if (!rst) begin
      if (addr == ADDR_CTRL) begin
        data_out = status;
      end else if (!fifo_empty) begin
        data_out = {24'b0, fifo_dout};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ien_reg     <= 1'b0;
      overrun_reg <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      if (wr_ctrl) ien_reg <= data_in[ST_IEN];
      if (ovr_set) begin
        overrun_reg <= 1'b1;
      end else if (wr_ctrl && data_in[ST_OVR]) begin
        overrun_reg <= 1'b0;
      end
      irq_reg <= ien_reg && (!fifo_empty || overrun_reg);
    end
  end

  assign irq = irq_reg;
  assign wt  = 1'b0;

  assign unused_data_in = ^{data_in[31:3], data_in[0]};

endmodule

// File: tb/tb_kbd_ctrl.sv
// Directed self-checking bench for kbd_ctrl; expectations adapt to KBD_CTRL_FIFO_EN.
module tb_kbd_ctrl;

`ifdef KBD_CTRL_FIFO_EN
  localparam int EFF = 8;
`else
  localparam int EFF = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_rdy = 1'b0;
  logic        en = 1'b0;
  logic        wr = 1'b0;
  logic        addr = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        wt;
  logic        irq;

  int tests_run = 0;
  int tests_failed = 0;

  kbd_ctrl #(.FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .en       (en),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .wt       (wt),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %08h", tag, got);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [7:0] b);
    rx_data = b; rx_rdy = 1'b1;
    @(posedge clk); #1;
    rx_rdy = 1'b0;
  endtask

  task automatic bus_write(input logic a, input logic [31:0] d);
    en = 1'b1; wr = 1'b1; addr = a; data_in = d;
    @(posedge clk); #1;
    en = 1'b0; wr = 1'b0; data_in = '0;
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    en = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    d = data_out;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  // Status word: count in 7:4, overrun bit2, ien bit1, ready bit0.
  function automatic logic [31:0] st(input int cnt, input bit ovr, input bit ie);
    logic [31:0] v;
    v = '0;
    v[7:4] = 4'(cnt);
    v[2] = ovr;
    v[1] = ie;
    v[0] = (cnt != 0);
    return v;
  endfunction

  logic [31:0] rd;

  initial begin
    // Reset: both addresses read 0 while rst is high
    repeat (2) idle();
    en = 1'b1; addr = 1'b0;
    @(negedge clk); check_eq("rst_ctrl_during", data_out, 32'h0);
    addr = 1'b1;
    @(negedge clk); check_eq("rst_data_during", data_out, 32'h0);
    @(posedge clk); #1;
    en = 1'b0; rst = 1'b0;
    bus_read(1'b0, rd); check_eq("reset_status", rd, 32'h0);
    check_eq("reset_irq", {31'b0, irq}, 32'h0);
    check_eq("wt_zero", {31'b0, wt}, 32'h0);

    // Two scancodes with interrupts enabled
    bus_write(1'b0, 32'h2);
    pulse(8'h1C);
    check_eq("irq_lag", {31'b0, irq}, 32'h0);
    pulse(8'hF0);
    check_eq("irq_raised", {31'b0, irq}, 32'h1);
    bus_read(1'b0, rd);
    check_eq("two_status", rd, (EFF > 1) ? 32'h23 : 32'h17);
    bus_read(1'b1, rd); check_eq("two_rd0", rd, 32'h1C);
    bus_read(1'b1, rd); check_eq("two_rd1", rd, (EFF > 1) ? 32'hF0 : 32'h0);
    bus_read(1'b0, rd);
    check_eq("two_status_after", rd, (EFF > 1) ? 32'h02 : 32'h06);
    idle();
    check_eq("two_irq_after", {31'b0, irq}, (EFF > 1) ? 32'h0 : 32'h1);
    bus_write(1'b0, 32'h4);

    // Overfill with no reads: last byte(s) lost, overrun set
    for (int i = 1; i <= 9; i++) pulse(8'(i));
    bus_read(1'b0, rd); check_eq("fill_status", rd, st(EFF, 1'b1, 1'b0));
    for (int i = 1; i <= EFF; i++) begin
      bus_read(1'b1, rd); check_eq($sformatf("fill_rd%0d", i), rd, 32'(i));
    end
    bus_read(1'b1, rd); check_eq("fill_empty_rd", rd, 32'h0);
    bus_write(1'b0, 32'h4);
    bus_read(1'b0, rd); check_eq("ovr_cleared", rd, 32'h0);

    // Full buffer: push coincident with pop, no overrun
    for (int i = 0; i < EFF; i++) pulse(8'(8'h10 + i));
    rx_data = 8'hAA; rx_rdy = 1'b1; en = 1'b1; wr = 1'b0; addr = 1'b1;
    @(negedge clk); rd = data_out;
    @(posedge clk); #1;
    rx_rdy = 1'b0; en = 1'b0;
    check_eq("coinc_rd", rd, 32'h10);
    bus_read(1'b0, rd); check_eq("coinc_status", rd, st(EFF, 1'b0, 1'b0));
    for (int i = 1; i < EFF; i++) begin
      bus_read(1'b1, rd); check_eq($sformatf("coinc_drain%0d", i), rd, 32'(8'h10 + i));
    end
    bus_read(1'b1, rd); check_eq("coinc_last", rd, 32'hAA);

    // Overrun set beats a same-cycle clear; irq masked while ien=0
    for (int i = 0; i < EFF; i++) pulse(8'(8'h30 + i));
    rx_data = 8'h3F; rx_rdy = 1'b1; en = 1'b1; wr = 1'b1; addr = 1'b0; data_in = 32'h4;
    @(posedge clk); #1;
    rx_rdy = 1'b0; en = 1'b0; wr = 1'b0; data_in = '0;
    bus_read(1'b0, rd); check_eq("set_wins", rd, st(EFF, 1'b1, 1'b0));
    check_eq("irq_masked", {31'b0, irq}, 32'h0);
    bus_write(1'b0, 32'h6);
    bus_read(1'b0, rd); check_eq("w1c_status", rd, st(EFF, 1'b0, 1'b1));
    check_eq("irq_ready", {31'b0, irq}, 32'h1);
    for (int i = 0; i < EFF; i++) bus_read(1'b1, rd);
    check_eq("drain_last", rd, 32'(8'h30 + EFF - 1));
    idle();
    check_eq("irq_drop", {31'b0, irq}, 32'h0);

    // Writes to the data register are ignored
    bus_write(1'b1, 32'hFFFF_FFFF);
    bus_read(1'b0, rd); check_eq("wr_data_ignored", rd, 32'h02);

    // Reset mid-operation discards buffer; inputs during rst ignored
    pulse(8'h51); pulse(8'h52); pulse(8'h53);
    bus_read(1'b0, rd); check_eq("pre_rst", rd, (EFF > 1) ? 32'h33 : 32'h17);
    rst = 1'b1; rx_data = 8'h77; rx_rdy = 1'b1; en = 1'b1; wr = 1'b1; addr = 1'b0; data_in = 32'h2;
    @(posedge clk); #1;
    rst = 1'b0; rx_rdy = 1'b0; en = 1'b0; wr = 1'b0; data_in = '0;
    bus_read(1'b0, rd); check_eq("post_rst_status", rd, 32'h0);
    bus_read(1'b1, rd); check_eq("post_rst_data", rd, 32'h0);
    check_eq("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
